// File: rtl/axon_dispatch.sv
// axon_dispatch: holds soma fire events for the axon delay, then emits one spike beat per fan-out target.
// Latency: an event already due at its accept edge N raises out_valid at edge N+2; FANOUT+2 cycles per event minimum.
// Backpressure: fire_ready drops when the pending FIFO is full; beats hold stable while out_valid && !out_ready.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   kill                      park the block in DEAD until the next rst
//   t_step                    advance cur_time by one
//   fire_valid/ready/time     incoming fire events; axon_delay is sampled at accept
//   w_we/w_addr/w_data        per-target weight table write
//   out_valid/ready           outgoing spike beats: out_target, out_spike (due time), out_weight
//   cur_time, o_busy          timestep counter and activity flag
// Optional: define AXON_DISPATCH_DROP_CNT_EN to add a saturating 16-bit drop_cnt output that counts
//   fire_valid cycles seen while the FIFO is full or the block is DEAD.
module axon_dispatch #(
  parameter int DEPTH  = 8,
  parameter int FANOUT = 4,
  parameter int TW     = (FANOUT > 1) ? $clog2(FANOUT) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          kill,
  input  logic          t_step,
  input  logic [7:0]    axon_delay,
  input  logic          fire_valid,
  output logic          fire_ready,
  input  logic [7:0]    fire_time,
  input  logic          w_we,
  input  logic [TW-1:0] w_addr,
  input  logic [7:0]    w_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [TW-1:0] out_target,
  output logic [7:0]    out_spike,
  output logic [7:0]    out_weight,
  output logic [7:0]    cur_time,
  output logic          o_busy
`ifdef AXON_DISPATCH_DROP_CNT_EN
  ,
  output logic [15:0]   drop_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, WAIT, DISPATCH, DEAD} state_t;

  state_t        state_q;
  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    weight_q [FANOUT];
  logic [TW-1:0] idx_q, idx_nxt;
  logic          out_valid_q;
  logic [TW-1:0] out_target_q;
  logic [7:0]    out_spike_q;
  logic [7:0]    out_weight_q;
  logic [7:0]    cur_time_q, cur_time_d;

  logic          full, push, pop, last_beat, head_due, w_in_range;
  logic [7:0]    due_in, head_q, due_diff;

  always_comb begin
    full       = (count_q == CW'(DEPTH));
    fire_ready = !full && (state_q != DEAD);
    push       = fire_valid && fire_ready;
    last_beat  = (idx_q == TW'(FANOUT - 1));
    pop        = (state_q == DISPATCH) && out_ready && last_beat;
    due_in     = fire_time + axon_delay;
    head_q     = mem_q[rptr_q];
    // Head is due when it lies at most 127 steps in the past; the 8-bit
    // difference makes this hold across the 255->0 wrap.
    due_diff   = cur_time_q - head_q;
    head_due   = (due_diff < 8'd128);
    idx_nxt    = idx_q + TW'(1);
    w_in_range = ({{(32-TW){1'b0}}, w_addr} < 32'(FANOUT));
    wptr_d     = push ? wptr_q + AW'(1) : wptr_q;
    rptr_d     = pop ? rptr_q + AW'(1) : rptr_q;
    count_d    = count_q + CW'(push) - CW'(pop);
    cur_time_d = t_step ? cur_time_q + 8'd1 : cur_time_q;
  end

  // Payload storage needs no reset: the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr_q] <= due_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      wptr_q       <= '0;
      rptr_q       <= '0;
      count_q      <= '0;
      idx_q        <= '0;
      out_valid_q  <= 1'b0;
      out_target_q <= '0;
      out_spike_q  <= '0;
      out_weight_q <= '0;
      cur_time_q   <= '0;
      for (int i = 0; i < FANOUT; i++) begin
        weight_q[i] <= '0;
      end
    end else begin
      cur_time_q <= cur_time_d;
      if (kill || (state_q == DEAD)) begin
        // Flush pending work and drop any beat in flight; only rst leaves DEAD.
        state_q     <= DEAD;
        wptr_q      <= '0;
        rptr_q      <= '0;
        count_q     <= '0;
        idx_q       <= '0;
        out_valid_q <= 1'b0;
      end else begin
        wptr_q  <= wptr_d;
        rptr_q  <= rptr_d;
        count_q <= count_d;
        if (w_we && w_in_range) begin
          weight_q[w_addr] <= w_data;
        end
        case (state_q)
          IDLE: begin
            if (count_q != '0) begin
              state_q <= WAIT;
            end
          end
          WAIT: begin
            if (head_due) begin
              state_q      <= DISPATCH;
              idx_q        <= '0;
              out_valid_q  <= 1'b1;
              out_target_q <= '0;
              out_spike_q  <= head_q;
              out_weight_q <= weight_q[0];
            end
          end
          DISPATCH: begin
            if (out_ready) begin
              if (last_beat) begin
                // Head is popped via pop/rptr_d; out_valid drops for at least the IDLE cycle.
                state_q     <= IDLE;
                idx_q       <= '0;
                out_valid_q <= 1'b0;
              end else begin
                idx_q        <= idx_nxt;
                out_target_q <= idx_nxt;
                out_weight_q <= weight_q[idx_nxt];
              end
            end
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

`ifdef AXON_DISPATCH_DROP_CNT_EN
  logic [15:0] drop_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt_q <= '0;
    end else if (fire_valid && (full || (state_q == DEAD)) && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign drop_cnt = drop_cnt_q;
`endif

  assign out_valid  = out_valid_q;
  assign out_target = out_target_q;
  assign out_spike  = out_spike_q;
  assign out_weight = out_weight_q;
  assign cur_time   = cur_time_q;
  assign o_busy     = (count_q != '0) || (state_q == DISPATCH);

endmodule

// File: tb/tb_axon_dispatch.sv
`timescale 1ns/1ps
module tb_axon_dispatch;
  localparam int DEPTH  = 8;
  localparam int FANOUT = 4;
  localparam int TW     = 2;

  logic clk = 1'b0;
  logic rst, kill, t_step, fire_valid, fire_ready, w_we, out_valid, out_ready, o_busy;
  logic [7:0] axon_delay, fire_time, w_data, out_spike, out_weight, cur_time;
  logic [TW-1:0] w_addr, out_target;
`ifdef AXON_DISPATCH_DROP_CNT_EN
  logic [15:0] drop_cnt;
`endif

  always #5 clk = ~clk;

  axon_dispatch #(.DEPTH(DEPTH), .FANOUT(FANOUT), .TW(TW)) dut (
    .clk(clk), .rst(rst), .kill(kill), .t_step(t_step), .axon_delay(axon_delay),
    .fire_valid(fire_valid), .fire_ready(fire_ready), .fire_time(fire_time),
    .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_target(out_target),
    .out_spike(out_spike), .out_weight(out_weight), .cur_time(cur_time), .o_busy(o_busy)
`ifdef AXON_DISPATCH_DROP_CNT_EN
    , .drop_cnt(drop_cnt)
`endif
  );

  // Reference model: pending events as a queue of due times, weight table, time, dead flag.
  int         checks = 0;
  int         failures = 0;
  logic [7:0] m_time;
  logic [7:0] exp_q[$];
  logic [7:0] wt[FANOUT];
  bit         dead;
  int         bidx;
  bit         held;
  logic [7:0] h_w;
  int         done_cnt = 0;
  int         drops;
  bit         acc;

  int         st, nc, nv, d0;
  bit         seen, hold;
  logic [7:0] base;

  typedef struct {
    logic [7:0] cur;
    logic [7:0] ft;
    logic [7:0] dly;
    logic [7:0] spike;
    int         steps;
  } vec_t;
  vec_t vt[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: score the handshakes visible now, take the edge, update the model, compare.
  task automatic cycle();
    logic [7:0] dd;
    logic [7:0] due;
    acc = 1'b0;
    if (!rst) begin
      if (fire_valid && (dead || exp_q.size() == DEPTH) && drops < 65535) drops++;
      acc = fire_valid && !dead && (exp_q.size() < DEPTH);
      if (out_valid) begin
        chk("beat_has_event", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          if (!held) begin
            held = 1'b1;
            h_w  = wt[bidx];
            dd   = m_time - exp_q[0];
            chk("beat_due", 32'(dd[7]), 0);
          end
          chk("beat_target", 32'(out_target), bidx);
          chk("beat_spike", 32'(out_spike), 32'(exp_q[0]));
          chk("beat_weight", 32'(out_weight), 32'(h_w));
          if (out_ready) begin
            held = 1'b0;
            bidx++;
            if (bidx == FANOUT) begin
              bidx = 0;
              void'(exp_q.pop_front());
              done_cnt++;
            end
          end
        end
      end
      if (acc) begin
        due = fire_time + axon_delay;
        exp_q.push_back(due);
      end
      if (w_we && !dead && !kill) wt[w_addr] = w_data;
    end
    @(posedge clk);
    #1;
    if (rst) begin
      m_time = 8'd0;
      exp_q.delete();
      for (int i = 0; i < FANOUT; i++) wt[i] = 8'd0;
      dead = 1'b0; bidx = 0; held = 1'b0; drops = 0;
    end else begin
      if (t_step) m_time = m_time + 8'd1;
      if (kill) begin
        dead = 1'b1; exp_q.delete(); bidx = 0; held = 1'b0;
      end
    end
    chk("cur_time", 32'(cur_time), 32'(m_time));
    chk("fire_ready", 32'(fire_ready), 32'(!dead && (exp_q.size() < DEPTH)));
    chk("o_busy", 32'(o_busy), 32'(exp_q.size() != 0));
    if (exp_q.size() == 0) chk("valid_idle", 32'(out_valid), 0);
`ifdef AXON_DISPATCH_DROP_CNT_EN
    chk("drop_cnt", 32'(drop_cnt), drops);
`endif
  endtask

  task automatic wr(input logic [TW-1:0] a, input logic [7:0] d);
    w_we = 1'b1; w_addr = a; w_data = d;
    cycle();
    w_we = 1'b0;
  endtask

  task automatic drain(input logic ts);
    fire_valid = 1'b0; out_ready = 1'b1; t_step = ts;
    for (int k = 0; k < 3000 && o_busy; k++) cycle();
    t_step = 1'b0;
    chk("drain_idle", 32'(o_busy), 0);
  endtask

  task automatic check_reset();
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_target", 32'(out_target), 0);
    chk("rst_spike", 32'(out_spike), 0);
    chk("rst_weight", 32'(out_weight), 0);
    chk("rst_time", 32'(cur_time), 0);
    chk("rst_ready", 32'(fire_ready), 1);
    chk("rst_busy", 32'(o_busy), 0);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{8'd10,  8'd10,  8'd3,   8'd13,  3};
    vt[1] = '{8'd254, 8'd254, 8'd4,   8'd2,   4};
    vt[2] = '{8'd20,  8'd15,  8'd2,   8'd17,  0};
    vt[3] = '{8'd100, 8'd100, 8'd0,   8'd100, 0};
    vt[4] = '{8'd0,   8'd200, 8'd100, 8'd44,  44};
    vt[5] = '{8'd50,  8'd50,  8'd127, 8'd177, 127};
    vt[6] = '{8'd60,  8'd60,  8'd128, 8'd188, 128};
    vt[7] = '{8'd5,   8'd5,   8'd255, 8'd4,   0};

    rst = 1'b1; kill = 1'b0; t_step = 1'b0; fire_valid = 1'b0; fire_time = '0; axon_delay = '0;
    w_we = 1'b0; w_addr = '0; w_data = '0; out_ready = 1'b0;
    m_time = '0; dead = 1'b0; bidx = 0; held = 1'b0; drops = 0; h_w = '0;
    cycle(); cycle();
    rst = 1'b0;
    check_reset();

    wr(0, 8'd5); wr(1, 8'd6); wr(2, 8'd7); wr(3, 8'd8);

    // Table: single events, counting t_step pulses until dispatch starts.
    for (int i = 0; i < 8; i++) begin
      t_step = 1'b1; fire_valid = 1'b0; out_ready = 1'b0;
      for (int k = 0; k < 300 && m_time != vt[i].cur; k++) cycle();
      t_step = 1'b0;
      fire_time = vt[i].ft; axon_delay = vt[i].dly; fire_valid = 1'b1;
      cycle();
      fire_valid = 1'b0;
      st = 0; seen = 1'b0;
      for (int k = 0; k < 200; k++) begin
        cycle(); cycle();
        if (out_valid) begin
          seen = 1'b1;
          break;
        end
        t_step = 1'b1; cycle(); t_step = 1'b0;
        st++;
      end
      chk("vec_seen", 32'(seen), 1);
      chk("vec_steps", st, vt[i].steps);
      chk("vec_spike", 32'(out_spike), 32'(vt[i].spike));
      chk("vec_target", 32'(out_target), 0);
      drain(1'b0);
    end

    // Latency and back-to-back throughput: two already-due events, out_ready high.
    t_step = 1'b0; out_ready = 1'b1; axon_delay = 8'd0; fire_time = m_time; fire_valid = 1'b1;
    cycle();
    chk("lat_n0", 32'(out_valid), 0);
    cycle();
    fire_valid = 1'b0;
    chk("lat_n1", 32'(out_valid), 0);
    cycle();
    chk("lat_n2", 32'(out_valid), 1);
    nc = 2; nv = 1;
    for (int k = 0; k < 40 && o_busy; k++) begin
      cycle();
      nc++;
      if (out_valid) nv++;
    end
    chk("two_evt_cycles", nc, 2 * (FANOUT + 2));
    chk("two_evt_beats", nv, 2 * FANOUT);

    // Backpressure on beat 1 with a weight write during the stall.
    fire_time = m_time; axon_delay = 8'd0; fire_valid = 1'b1;
    cycle();
    fire_valid = 1'b0;
    for (int k = 0; k < 20 && !(out_valid && out_target == 2'd1); k++) cycle();
    out_ready = 1'b0;
    for (int s = 0; s < 5; s++) begin
      w_we = (s == 1); w_addr = 2'd1; w_data = 8'd99;
      cycle();
      w_we = 1'b0;
      chk("bp_valid", 32'(out_valid), 1);
      chk("bp_target", 32'(out_target), 1);
      chk("bp_weight", 32'(out_weight), 6);
    end
    out_ready = 1'b1;
    cycle();
    chk("bp_next_tgt", 32'(out_target), 2);
    chk("bp_next_w", 32'(out_weight), 7);
    drain(1'b0);
    fire_time = m_time; fire_valid = 1'b1;
    cycle();
    fire_valid = 1'b0;
    for (int k = 0; k < 20 && !(out_valid && out_target == 2'd1); k++) cycle();
    chk("wt_new", 32'(out_weight), 99);
    drain(1'b0);
    wr(1, 8'd6);

    // Randomized traffic against the queue model; the source holds unaccepted events.
    hold = 1'b0;
    for (int k = 0; k < 600; k++) begin
      if (!hold) begin
        fire_valid = ($urandom_range(0, 99) < 35);
        fire_time  = m_time - 8'($urandom_range(0, 5));
        axon_delay = 8'($urandom_range(0, 20));
      end
      t_step    = ($urandom_range(0, 99) < 30);
      out_ready = ($urandom_range(0, 99) < 70);
      cycle();
      hold = fire_valid && !acc;
    end
    drain(1'b1);

    // FIFO full, drop counting, refill after the first pop.
    rst = 1'b1; cycle(); rst = 1'b0;
    check_reset();
    wr(0, 8'd5); wr(1, 8'd6); wr(2, 8'd7); wr(3, 8'd8);
    t_step = 1'b0; out_ready = 1'b1; axon_delay = 8'd0; base = m_time;
    for (int i = 0; i < DEPTH; i++) begin
      fire_time = base + 8'(10 + i); fire_valid = 1'b1;
      chk("full_rdy_pre", 32'(fire_ready), 1);
      cycle();
    end
    fire_time = base + 8'd18;
    chk("full_rdy_ninth", 32'(fire_ready), 0);
    cycle(); cycle(); cycle();
`ifdef AXON_DISPATCH_DROP_CNT_EN
    chk("drop_full", 32'(drop_cnt), 3);
`endif
    fire_valid = 1'b0; t_step = 1'b1; d0 = done_cnt;
    for (int k = 0; k < 300 && !fire_ready; k++) begin
      cycle();
      if (m_time == base + 8'd20) t_step = 1'b0;
    end
    chk("one_pop", done_cnt - d0, 1);
    fire_valid = 1'b1;
    cycle();
    fire_valid = 1'b0;
    if (m_time == base + 8'd20) t_step = 1'b0;

    // Kill during beat 2.
    for (int k = 0; k < 200 && !(out_valid && out_target == 2'd2); k++) begin
      cycle();
      if (m_time == base + 8'd20) t_step = 1'b0;
    end
    chk("kill_reached", 32'(out_target), 2);
    t_step = 1'b0;
    kill = 1'b1; cycle(); kill = 1'b0;
    chk("dead_valid", 32'(out_valid), 0);
    chk("dead_ready", 32'(fire_ready), 0);
    chk("dead_busy", 32'(o_busy), 0);
    fire_valid = 1'b1; cycle(); cycle(); fire_valid = 1'b0;
    chk("dead_busy2", 32'(o_busy), 0);
`ifdef AXON_DISPATCH_DROP_CNT_EN
    chk("drop_dead", 32'(drop_cnt), 5);
`endif
    rst = 1'b1; cycle(); rst = 1'b0;
    check_reset();

    // Normal operation after recovery.
    wr(0, 8'd3); wr(1, 8'd1); wr(2, 8'd4); wr(3, 8'd9);
    fire_time = m_time; axon_delay = 8'd2; fire_valid = 1'b1;
    cycle();
    fire_valid = 1'b0;
    drain(1'b1);
    chk("resume_done", 32'(out_valid), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
